// File: rtl/data_sram_resp.sv
// Data-side SRAM responder: single-port word RAM plus a small MMIO block (LED, timer).
// Every request answers the next cycle; rdata holds between requests.
module data_sram_resp #(
    parameter int unsigned RAM_AW    = 10,
    parameter logic [15:0] MMIO_BASE = 16'hBFAF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_we,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    output logic [15:0] led,
    output logic        timer_irq
);

    localparam logic [15:0] OffLed   = 16'hF000;
    localparam logic [15:0] OffCount = 16'hE000;
    localparam logic [15:0] OffCmp   = 16'hE004;
    localparam logic [15:0] OffCtrl  = 16'hE008;

    typedef enum logic [1:0] {SrcZero, SrcRam, SrcReg} src_e;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] be);
        logic [31:0] res;
        res = old;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) res[8*i +: 8] = wd[8*i +: 8];
        end
        return res;
    endfunction

    logic              accept;
    logic              is_mmio;
    logic              ram_acc;
    logic              reg_acc;
    logic [15:0]       offset;
    logic [RAM_AW-1:0] ram_idx;

    logic [31:0] mem [2**RAM_AW];
    logic [31:0] ram_q;

    logic [15:0] led_q, led_d;
    logic [31:0] count_q, count_d;
    logic [31:0] cmp_q, cmp_d;
    logic        ctrl_en_q, ctrl_en_d;
    logic        pend_q, pend_d;
    logic [31:0] reg_q, reg_d;
    logic [31:0] reg_rd;
    src_e        src_q, src_d;

    // Requests seen while reset is high are dropped, including RAM writes.
    assign accept  = data_sram_en && !reset;
    assign is_mmio = (data_sram_addr[31:16] == MMIO_BASE);
    assign ram_acc = accept && !is_mmio;
    assign reg_acc = accept && is_mmio;
    assign offset  = data_sram_addr[15:0];
    assign ram_idx = data_sram_addr[RAM_AW+1:2];

    // Read-first single-port array without reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (ram_acc) begin
            for (int i = 0; i < 4; i++) begin
                if (data_sram_we[i]) mem[ram_idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
            end
            ram_q <= mem[ram_idx];
        end
    end

    always_comb begin
        reg_rd = 32'h0;
        unique case (offset)
            OffLed:   reg_rd = {16'h0, led_q};
            OffCount: reg_rd = count_q;
            OffCmp:   reg_rd = cmp_q;
            OffCtrl:  reg_rd = {30'h0, pend_q, ctrl_en_q};
            default:  reg_rd = 32'h0;
        endcase
    end

    always_comb begin
        logic [31:0] led_m;
        logic [31:0] ctrl_m;
        led_d     = led_q;
        count_d   = count_q;
        cmp_d     = cmp_q;
        ctrl_en_d = ctrl_en_q;
        pend_d    = pend_q;
        reg_d     = reg_q;
        src_d     = src_q;
        led_m     = merge({16'h0, led_q}, data_sram_wdata, data_sram_we);
        ctrl_m    = merge({30'h0, pend_q, ctrl_en_q}, data_sram_wdata, data_sram_we);

        if (ctrl_en_q) count_d = count_q + 32'd1;

        if (accept) src_d = is_mmio ? SrcReg : SrcRam;

        if (reg_acc) begin
            reg_d = reg_rd;
            if (data_sram_we != 4'h0) begin
                unique case (offset)
                    OffLed:   led_d = led_m[15:0];
                    OffCount: count_d = merge(count_q, data_sram_wdata, data_sram_we);
                    OffCmp:   cmp_d = merge(cmp_q, data_sram_wdata, data_sram_we);
                    OffCtrl: begin
                        ctrl_en_d = ctrl_m[0];
                        if (ctrl_m[1]) pend_d = 1'b0;
                    end
                    default: ;
                endcase
            end
        end

        // Compare uses pre-edge COUNT and beats a simultaneous W1C.
        if (ctrl_en_q && (count_q == cmp_q)) pend_d = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            led_q     <= 16'h0;
            count_q   <= 32'h0;
            cmp_q     <= 32'hFFFF_FFFF;
            ctrl_en_q <= 1'b0;
            pend_q    <= 1'b0;
            reg_q     <= 32'h0;
            src_q     <= SrcZero;
        end else begin
            led_q     <= led_d;
            count_q   <= count_d;
            cmp_q     <= cmp_d;
            ctrl_en_q <= ctrl_en_d;
            pend_q    <= pend_d;
            reg_q     <= reg_d;
            src_q     <= src_d;
        end
    end

    always_comb begin
        data_sram_rdata = 32'h0;
        unique case (src_q)
            SrcRam:  data_sram_rdata = ram_q;
            SrcReg:  data_sram_rdata = reg_q;
            default: data_sram_rdata = 32'h0;
        endcase
    end

    assign led       = led_q;
    assign timer_irq = pend_q;

endmodule

// File: tb/tb_data_sram_resp.sv
// Directed bench for data_sram_resp: RAM byte writes, LED, timer compare/W1C, COUNT wrap, reset.
module tb_data_sram_resp;

    logic        clk = 1'b0;
    logic        reset;
    logic        data_sram_en;
    logic [3:0]  data_sram_we;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata;
    logic [15:0] led;
    logic        timer_irq;

    int passed = 0;
    int total  = 0;

    localparam logic [31:0] RamA   = 32'h1C00_0100;
    localparam logic [31:0] RamAl  = 32'h1C00_1100;
    localparam logic [31:0] LedA   = 32'hBFAF_F000;
    localparam logic [31:0] CountA = 32'hBFAF_E000;
    localparam logic [31:0] CmpA   = 32'hBFAF_E004;
    localparam logic [31:0] CtrlA  = 32'hBFAF_E008;
    localparam logic [31:0] UnmapA = 32'hBFAF_1234;

    data_sram_resp dut (
        .clk             (clk),
        .reset           (reset),
        .data_sram_en    (data_sram_en),
        .data_sram_we    (data_sram_we),
        .data_sram_addr  (data_sram_addr),
        .data_sram_wdata (data_sram_wdata),
        .data_sram_rdata (data_sram_rdata),
        .led             (led),
        .timer_irq       (timer_irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Present one request for one edge; returns #1 after that edge.
    task automatic req(input logic [3:0] we, input logic [31:0] addr, input logic [31:0] wd);
        data_sram_en    = 1'b1;
        data_sram_we    = we;
        data_sram_addr  = addr;
        data_sram_wdata = wd;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        data_sram_en = 1'b0;
        data_sram_we = 4'h0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset           = 1'b1;
        data_sram_en    = 1'b0;
        data_sram_we    = 4'h0;
        data_sram_addr  = 32'h0;
        data_sram_wdata = 32'h0;
        #2;
        chk("rst_rdata", data_sram_rdata, 32'h0);
        chk("rst_led", {16'h0, led}, 32'h0);
        chk("rst_irq", {31'h0, timer_irq}, 32'h0);

        // A write during reset must be dropped.
        req(4'hF, LedA, 32'h0000_FFFF);
        chk("rst_drop_led", {16'h0, led}, 32'h0);
        chk("rst_drop_rdata", data_sram_rdata, 32'h0);
        data_sram_en = 1'b0;
        @(negedge clk);
        reset = 1'b0;

        req(4'h0, CmpA, 32'h0);
        chk("cmp_reset_val", data_sram_rdata, 32'hFFFF_FFFF);

        req(4'hF, RamA, 32'h1234_5678);
        req(4'h0, RamA, 32'h0);
        chk("ram_full_word", data_sram_rdata, 32'h1234_5678);
        req(4'b0101, RamA, 32'hAABB_CCDD);
        chk("ram_read_first", data_sram_rdata, 32'h1234_5678);
        req(4'h0, RamA, 32'h0);
        chk("ram_byte_merge", data_sram_rdata, 32'h12BB_56DD);
        idle();
        chk("rdata_hold", data_sram_rdata, 32'h12BB_56DD);
        req(4'h0, RamAl, 32'h0);
        chk("ram_alias", data_sram_rdata, 32'h12BB_56DD);

        req(4'h3, LedA, 32'hDEAD_00FF);
        chk("led_write", {16'h0, led}, 32'h0000_00FF);
        req(4'h0, LedA, 32'h0);
        chk("led_read", data_sram_rdata, 32'h0000_00FF);
        req(4'b0010, LedA, 32'h0000_A500);
        chk("led_byte_lane", {16'h0, led}, 32'h0000_A5FF);

        req(4'hF, UnmapA, 32'hFFFF_FFFF);
        req(4'h0, UnmapA, 32'h0);
        chk("unmapped_read", data_sram_rdata, 32'h0);

        // Timer: CTRL write at edge W; PEND expected at edge W+6.
        req(4'hF, CmpA, 32'd5);
        req(4'hF, CountA, 32'd0);
        req(4'hF, CtrlA, 32'd1);
        repeat (5) idle();
        chk("irq_before_match", {31'h0, timer_irq}, 32'h0);
        idle();
        chk("irq_at_match", {31'h0, timer_irq}, 32'h1);
        req(4'h0, CountA, 32'h0);
        chk("count_pre_edge", data_sram_rdata, 32'd6);
        req(4'hF, CtrlA, 32'd3);
        chk("ctrl_read_pend", data_sram_rdata, 32'd3);
        chk("irq_w1c", {31'h0, timer_irq}, 32'h0);
        req(4'h0, CountA, 32'h0);
        chk("count_keeps_going", data_sram_rdata, 32'd8);
        req(4'h0, CtrlA, 32'h0);
        chk("ctrl_en_only", data_sram_rdata, 32'd1);

        // COUNT wrap and load-over-increment.
        req(4'hF, CountA, 32'hFFFF_FFFE);
        chk("count_before_load", data_sram_rdata, 32'd10);
        req(4'h0, CountA, 32'h0);
        chk("count_loaded", data_sram_rdata, 32'hFFFF_FFFE);
        req(4'h0, CountA, 32'h0);
        chk("count_max", data_sram_rdata, 32'hFFFF_FFFF);
        req(4'h0, CountA, 32'h0);
        chk("count_wrap", data_sram_rdata, 32'h0);
        req(4'hF, CountA, 32'h0000_0100);
        req(4'h0, CountA, 32'h0);
        chk("count_exact_load", data_sram_rdata, 32'h0000_0100);

        // Re-arm PEND so reset has something to clear.
        req(4'hF, CountA, 32'h20);
        req(4'hF, CmpA, 32'h21);
        idle();
        chk("irq_rearm", {31'h0, timer_irq}, 32'h1);

        req(4'h0, RamA, 32'h0);
        chk("inflight_read", data_sram_rdata, 32'h12BB_56DD);
        reset = 1'b1;
        #1;
        chk("mid_rst_rdata", data_sram_rdata, 32'h0);
        chk("mid_rst_led", {16'h0, led}, 32'h0);
        chk("mid_rst_irq", {31'h0, timer_irq}, 32'h0);
        data_sram_en = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        req(4'h0, CmpA, 32'h0);
        chk("post_rst_cmp", data_sram_rdata, 32'hFFFF_FFFF);
        req(4'h0, CountA, 32'h0);
        chk("post_rst_count", data_sram_rdata, 32'h0);
        req(4'h0, CountA, 32'h0);
        chk("count_hold_dis", data_sram_rdata, 32'h0);
        req(4'h0, CtrlA, 32'h0);
        chk("post_rst_ctrl", data_sram_rdata, 32'h0);
        idle();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/data_sram_resp.md
DATA_SRAM_RESP -- requirements
Module: data_sram_resp

Interface
REQ-001 Parameter RAM_AW, default 10: word-address width of the internal data RAM, giving 2^RAM_AW 32-bit words.
REQ-002 Parameter MMIO_BASE, default 16'hBFAF: value of addr[31:16] that selects the register space instead of RAM.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 data_sram_en  input  1  access request for this cycle.
REQ-006 data_sram_we  input  4  byte write enables; bit i covers wdata[8i+7:8i]; 0 means read.
REQ-007 data_sram_addr  input  32  byte address; addr[1:0] ignored.
REQ-008 data_sram_wdata  input  32  write data.
REQ-009 data_sram_rdata  output  32  registered read data, valid the cycle after the request.
REQ-010 led  output  16  LED register contents.
REQ-011 timer_irq  output  1  level, equal to ctrl.PEND.

Function
REQ-012 Request: en=1 at edge N is accepted; no stall and no backpressure; one access per cycle, back-to-back allowed.
REQ-013 Read (en=1, we=0): rdata after edge N = word at addr as it stood before edge N; fixed 1-cycle latency.
REQ-014 Write (en=1, we!=0): only lanes with we[i]=1 updated at edge N; rdata after edge N = pre-write word (read-first).
REQ-015 en=0: rdata holds its last value; no state change except timer.
REQ-016 Decode: addr[31:16]==MMIO_BASE -> register space; else RAM at index addr[RAM_AW+1:2]; upper bits ignored (aliasing).
REQ-017 Registers (offset = addr[15:0]): 16'hF000 LED (RW, bits 15:0; bits 31:16 read 0, writes ignored); 16'hE000 COUNT (RW); 16'hE004 CMP (RW); 16'hE008 CTRL (bit0 EN RW, bit1 PEND W1C, other bits read 0).
REQ-018 Unmapped register offsets: read 0, writes ignored.
REQ-019 Byte enables apply to registers exactly as to RAM.
REQ-020 COUNT: +1 every cycle when EN=1; wraps 32'hFFFFFFFF -> 0; holds when EN=0.
REQ-021 COUNT write and increment in the same cycle: written value loaded, no increment that cycle.
REQ-022 PEND set at edge where EN=1 and COUNT (pre-edge value) == CMP.
REQ-023 PEND set and W1C clear in the same cycle: set wins.
REQ-024 COUNT read returns pre-edge value, i.e. before that cycle's increment.
REQ-025 Clearing EN does not clear PEND.
REQ-026 RAM implemented as synchronous single-port array, inferable as block RAM.

Reset
REQ-027 While reset=1: rdata=0, led=0, COUNT=0, CMP=32'hFFFFFFFF, CTRL=0, timer_irq=0, asynchronously.
REQ-028 RAM contents not reset; reads before any write are undefined.
REQ-029 Requests presented while reset=1 are dropped; reset asserted mid-sequence discards in-flight read data (rdata=0).
REQ-030 First request accepted at first rising edge with reset=0.

Verification
REQ-031 Write 32'h12345678 to 32'h1C000100 with we=4'hF, then read it -> rdata=32'h12345678 one cycle after the read request.
REQ-032 Same word, write 32'hAABBCCDD with we=4'b0101, then read -> 32'h12BB56DD; rdata after the write cycle = 32'h12345678.
REQ-033 Write 16'h00FF to 32'hBFAFF000 with we=4'h3 -> led=16'h00FF; read returns 32'h000000FF.
REQ-034 CMP=5, COUNT=0, CTRL=1 -> timer_irq rises the 6th edge after the CTRL write; W1C write of 2 to CTRL clears it; COUNT keeps counting.
REQ-035 COUNT=32'hFFFFFFFE with EN=1 -> reads across 3 cycles show wrap through 0; writing COUNT while running loads the exact value.
REQ-036 Assert reset between a read request and its data cycle -> rdata=0, led=0, timer_irq=0; post-reset CMP read = 32'hFFFFFFFF.
